// File: rtl/mem_lock_arbiter_pkg.sv
// Shared types and helpers for the data-memory lock/request responder.
//   mem_rpl_t   : per-requester control (req, issue id, release_lock)
//   mem_req_t   : per-requester memory access (addr, wdata, wen)
//   id_older()  : wrap-aware program-age comparison
//   idx_width() : index width for an N-entry selector (minimum 1)
package mem_lock_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH   = 30;
  localparam int unsigned DATA_WIDTH   = 32;
  // Issue ids are carried zero-extended to this width; the age test masks
  // back down to the real id width, so the low bits of the difference decide.
  localparam int unsigned MAX_ID_WIDTH = 16;

  typedef enum logic {
    ST_FREE,
    ST_HELD
  } lock_state_e;

  typedef struct packed {
    logic                    req;
    logic [MAX_ID_WIDTH-1:0] req_issue_id;
    logic                    release_lock;
  } mem_rpl_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wen;
  } mem_req_t;

  // a is older than b when the top id bit of (a - b) mod 2^width is set.
  function automatic logic id_older(input logic [MAX_ID_WIDTH-1:0] a,
                                    input logic [MAX_ID_WIDTH-1:0] b,
                                    input int unsigned             width);
    logic [MAX_ID_WIDTH-1:0] diff;
    diff = a - b;
    return (diff & (MAX_ID_WIDTH'(1) << (width - 1))) != '0;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_lock_arbiter_age_pick.sv
// mem_age_pick: combinational oldest-requester selector.
//   req      : per-port request
//   issue_id : per-port issue id, packed NUM_PORTS x ID_WIDTH
//   valid    : at least one port requests
//   index    : oldest requesting port; equal ids resolve to the lower index
module mem_age_pick
  import mem_lock_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 4,
  parameter  int unsigned ID_WIDTH  = 6,
  localparam int unsigned IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS*ID_WIDTH-1:0] issue_id,
  output logic                          valid,
  output logic [IDX_W-1:0]              index
);

  logic [MAX_ID_WIDTH-1:0] best_id;
  logic [MAX_ID_WIDTH-1:0] cur_id;

  // Linear scan from port 0 upward; a later port only displaces the current
  // best when strictly older, which gives the lower-index tie-break.
  always_comb begin
    valid   = 1'b0;
    index   = '0;
    best_id = '0;
    cur_id  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cur_id = MAX_ID_WIDTH'(issue_id[i*ID_WIDTH +: ID_WIDTH]);
      if (req[i] && (!valid || id_older(cur_id, best_id, ID_WIDTH))) begin
        valid   = 1'b1;
        index   = IDX_W'(i);
        best_id = cur_id;
      end
    end
  end

endmodule

// File: rtl/mem_lock_arbiter.sv
// mem_lock_arbiter: responder for the Mem sub-SIC lock/request protocol.
// Grants the oldest requester (by issue id) combinationally, optionally holds
// a multi-cycle lock for that port until release_lock, and steers the granted
// port onto the single async-read data-memory port.
//   port_req/issue_id/release : per-port protocol controls
//   port_addr/wdata/wen       : per-port memory access
//   port_grant                : one-hot or zero grant
//   port_rdata                : dmem_rdata broadcast to all ports
//   dmem_addr/wdata/wen/rdata : data-memory port
//   locked                    : a lock is currently held
//   contention_cnt            : saturating count of cycles with >=2 requests
module mem_lock_arbiter
  import mem_lock_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ID_WIDTH  = 6,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            port_req,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]   port_issue_id,
  input  logic [NUM_PORTS-1:0]            port_release,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata,
  input  logic [NUM_PORTS-1:0]            port_wen,
  output logic [NUM_PORTS-1:0]            port_grant,
  output logic [DATA_WIDTH-1:0]           port_rdata,
  output logic [ADDR_WIDTH-1:0]           dmem_addr,
  output logic [DATA_WIDTH-1:0]           dmem_wdata,
  output logic                            dmem_wen,
  input  logic [DATA_WIDTH-1:0]           dmem_rdata,
  output logic                            locked,
  output logic [CNT_WIDTH-1:0]            contention_cnt
);

  localparam int unsigned IDX_W = idx_width(NUM_PORTS);

  mem_rpl_t               rpl  [NUM_PORTS];
  mem_req_t               mreq [NUM_PORTS];

  lock_state_e            state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]   grant;
  logic [IDX_W-1:0]       sel;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_index;
  logic                   contention;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      rpl[i].req           = port_req[i];
      rpl[i].req_issue_id  = MAX_ID_WIDTH'(port_issue_id[i*ID_WIDTH +: ID_WIDTH]);
      rpl[i].release_lock  = port_release[i];
      mreq[i].addr         = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      mreq[i].wdata        = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      mreq[i].wen          = port_wen[i];
    end
  end

  mem_age_pick #(
    .NUM_PORTS (NUM_PORTS),
    .ID_WIDTH  (ID_WIDTH)
  ) u_age_pick (
    .req      (port_req),
    .issue_id (port_issue_id),
    .valid    (pick_valid),
    .index    (pick_index)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant   = '0;
    sel     = '0;
    unique case (state_q)
      ST_FREE: begin
        if (pick_valid) begin
          grant[pick_index] = 1'b1;
          sel               = pick_index;
          if (!rpl[pick_index].release_lock) begin
            state_d = ST_HELD;
            owner_d = pick_index;
          end
        end
      end
      ST_HELD: begin
        if (rpl[owner_q].req) begin
          grant[owner_q] = 1'b1;
          sel            = owner_q;
          if (rpl[owner_q].release_lock) state_d = ST_FREE;
        end else begin
          // Owner abort: drop the lock with no grant and no write.
          state_d = ST_FREE;
        end
      end
      default: state_d = ST_FREE;
    endcase
    // The state flops clear asynchronously, but in FREE the grant would still
    // follow port_req; gate it so nothing is granted or written while in reset.
    if (!rst_n) grant = '0;
  end

  assign contention = (port_req & (port_req - NUM_PORTS'(1))) != '0;

  always_comb begin
    cnt_d = cnt_q;
    if (contention && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FREE;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign port_grant     = grant;
  assign dmem_addr      = mreq[sel].addr;
  assign dmem_wdata     = mreq[sel].wdata;
  assign dmem_wen       = (|grant) & mreq[sel].wen;
  assign port_rdata     = dmem_rdata;
  assign locked         = (state_q == ST_HELD);
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_mem_lock_arbiter.sv
module tb_mem_lock_arbiter;

  localparam int NP = 4;
  localparam int IW = 6;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     port_req, port_release, port_wen, port_grant;
  logic [NP*IW-1:0]  port_issue_id;
  logic [NP*30-1:0]  port_addr;
  logic [NP*32-1:0]  port_wdata;
  logic [31:0]       port_rdata, dmem_wdata, dmem_rdata;
  logic [29:0]       dmem_addr;
  logic              dmem_wen, locked;
  logic [CW-1:0]     contention_cnt;

  logic [IW-1:0]     id_a    [NP];
  logic [29:0]       addr_a  [NP];
  logic [31:0]       wdata_a [NP];

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit          m_held;
  int          m_owner;
  int          m_cnt;
  int          win;
  logic [NP-1:0] exp_grant;
  logic [29:0] exp_addr;
  logic [31:0] exp_wdata, exp_rdata;
  logic        exp_wen, exp_locked;
  logic [CW-1:0] exp_cnt;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      port_issue_id[i*IW +: IW] = id_a[i];
      port_addr[i*30 +: 30]     = addr_a[i];
      port_wdata[i*32 +: 32]    = wdata_a[i];
    end
  end

  assign dmem_rdata = {2'b00, dmem_addr} ^ 32'h5A5A_0000;

  mem_lock_arbiter #(
    .NUM_PORTS (NP),
    .ID_WIDTH  (IW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .port_req       (port_req),
    .port_issue_id  (port_issue_id),
    .port_release   (port_release),
    .port_addr      (port_addr),
    .port_wdata     (port_wdata),
    .port_wen       (port_wen),
    .port_grant     (port_grant),
    .port_rdata     (port_rdata),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wen       (dmem_wen),
    .dmem_rdata     (dmem_rdata),
    .locked         (locked),
    .contention_cnt (contention_cnt)
  );

  function automatic bit older(int a, int b);
    int d;
    d = ((a - b) % 64 + 64) % 64;
    return d >= 32;
  endfunction

  function automatic int popcount(logic [NP-1:0] v);
    int c = 0;
    for (int i = 0; i < NP; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic clear_inputs();
    port_req = '0; port_release = '0; port_wen = '0;
    for (int i = 0; i < NP; i++) begin
      id_a[i] = '0; addr_a[i] = 30'(i * 4 + 1); wdata_a[i] = 32'(i) ^ 32'hC0DE_0000;
    end
  endtask

  // Winner: a requesting port that no other requester beats on age or tie rank.
  task automatic model_eval();
    int sel;
    win = -1;
    if (m_held) begin
      if (port_req[m_owner]) win = m_owner;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (port_req[i]) begin
          bit beaten = 0;
          for (int j = 0; j < NP; j++)
            if (j != i && port_req[j] &&
                (older(int'(id_a[j]), int'(id_a[i])) || (id_a[j] == id_a[i] && j < i)))
              beaten = 1;
          if (!beaten) win = i;
        end
      end
    end
    sel        = (win >= 0) ? win : 0;
    exp_grant  = (win >= 0) ? NP'(1 << win) : '0;
    exp_addr   = addr_a[sel];
    exp_wdata  = wdata_a[sel];
    exp_wen    = (win >= 0) && port_wen[win];
    exp_rdata  = {2'b00, exp_addr} ^ 32'h5A5A_0000;
    exp_locked = m_held;
    exp_cnt    = CW'(m_cnt);
  endtask

  task automatic settle();
    model_eval();
    #3;
  endtask

  task automatic advance();
    @(posedge clk);
    if (win >= 0) begin
      if (m_held) begin
        if (port_release[win]) m_held = 0;
      end else if (!port_release[win]) begin
        m_held = 1; m_owner = win;
      end
    end else if (m_held) begin
      m_held = 0;
    end
    if (popcount(port_req) >= 2 && m_cnt < 15) m_cnt++;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    port_req = 4'b0011; port_wen = 4'b0011; addr_a[0] = 30'h123;
    #12;
    n_vec++; if (port_grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got %b exp 0000", port_grant); end
    n_vec++; if (dmem_wen !== 1'b0) begin n_err++; $display("FAIL reset_wen got %b exp 0", dmem_wen); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got %b exp 0", locked); end
    n_vec++; if (contention_cnt !== '0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", contention_cnt); end
    n_vec++; if (dmem_addr !== 30'h123) begin n_err++; $display("FAIL reset_addr got %h exp 123", dmem_addr); end
    clear_inputs();
    m_held = 0; m_owner = 0; m_cnt = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_cycle();
    clear_inputs();
    port_req = 4'b0100; port_release = 4'b0100; port_wen = 4'b0100;
    id_a[2] = 6'd5; addr_a[2] = 30'h10; wdata_a[2] = 32'hDEAD_BEEF;
    settle();
    n_vec++; if (port_grant !== 4'b0100) begin n_err++; $display("FAIL single_grant got %b exp 0100", port_grant); end
    n_vec++; if (dmem_wen !== 1'b1) begin n_err++; $display("FAIL single_wen got %b exp 1", dmem_wen); end
    n_vec++; if (dmem_addr !== 30'h10) begin n_err++; $display("FAIL single_addr got %h exp 10", dmem_addr); end
    n_vec++; if (dmem_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_wdata got %h exp deadbeef", dmem_wdata); end
    n_vec++; if (port_rdata !== exp_rdata) begin n_err++; $display("FAIL single_rdata got %h exp %h", port_rdata, exp_rdata); end
    advance();
    clear_inputs(); settle();
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL single_free got %b exp 0", locked); end
  endtask

  task automatic test_wrap_arbitration();
    int cnt0;
    cnt0 = m_cnt;
    clear_inputs();
    port_req = 4'b1011; port_release = 4'b1011;
    id_a[0] = 6'd10; id_a[1] = 6'd3; id_a[3] = 6'd63;
    settle();
    n_vec++; if (port_grant !== 4'b1000) begin n_err++; $display("FAIL wrap_grant got %b exp 1000", port_grant); end
    advance();
    clear_inputs(); settle();
    n_vec++; if (contention_cnt !== CW'(cnt0 + 1)) begin n_err++; $display("FAIL wrap_cnt got %0d exp %0d", contention_cnt, cnt0 + 1); end
  endtask

  task automatic test_tie_break();
    clear_inputs();
    port_req = 4'b0110; port_release = 4'b0110;
    id_a[1] = 6'd7; id_a[2] = 6'd7;
    settle();
    n_vec++; if (port_grant !== 4'b0010) begin n_err++; $display("FAIL tie_grant got %b exp 0010", port_grant); end
    advance();
  endtask

  task automatic test_multi_cycle_lock();
    clear_inputs();
    id_a[0] = 6'd20; id_a[1] = 6'd4;
    port_req = 4'b0001;
    settle();
    n_vec++; if (port_grant !== 4'b0001) begin n_err++; $display("FAIL lock_c1_grant got %b exp 0001", port_grant); end
    advance();
    port_req = 4'b0011; port_release = 4'b0010;
    settle();
    n_vec++; if (port_grant !== 4'b0001) begin n_err++; $display("FAIL lock_c2_grant got %b exp 0001", port_grant); end
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL lock_c2_locked got %b exp 1", locked); end
    advance();
    port_release = 4'b0011;
    settle();
    n_vec++; if (port_grant !== 4'b0001) begin n_err++; $display("FAIL lock_c3_grant got %b exp 0001", port_grant); end
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL lock_c3_locked got %b exp 1", locked); end
    advance();
    port_req = 4'b0010; port_release = 4'b0010;
    settle();
    n_vec++; if (port_grant !== 4'b0010) begin n_err++; $display("FAIL lock_c4_grant got %b exp 0010", port_grant); end
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL lock_c4_locked got %b exp 0", locked); end
    advance();
  endtask

  task automatic test_abort();
    clear_inputs();
    port_wen = 4'b1111;
    id_a[2] = 6'd9; id_a[3] = 6'd11;
    port_req = 4'b0100;
    settle();
    n_vec++; if (port_grant !== 4'b0100) begin n_err++; $display("FAIL abort_take got %b exp 0100", port_grant); end
    advance();
    port_req = 4'b1000;
    settle();
    n_vec++; if (port_grant !== 4'b0000) begin n_err++; $display("FAIL abort_grant got %b exp 0000", port_grant); end
    n_vec++; if (dmem_wen !== 1'b0) begin n_err++; $display("FAIL abort_wen got %b exp 0", dmem_wen); end
    advance();
    port_release = 4'b1000;
    settle();
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL abort_free got %b exp 0", locked); end
    n_vec++; if (port_grant !== 4'b1000) begin n_err++; $display("FAIL abort_next got %b exp 1000", port_grant); end
    advance();
  endtask

  task automatic test_reset_mid_lock();
    clear_inputs();
    port_wen = 4'b1111;
    port_req = 4'b0001;
    settle(); advance();
    port_req = 4'b0011;
    settle();
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL rstlock_pre got %b exp 1", locked); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL rstlock_locked got %b exp 0", locked); end
    n_vec++; if (port_grant !== 4'b0000) begin n_err++; $display("FAIL rstlock_grant got %b exp 0000", port_grant); end
    n_vec++; if (dmem_wen !== 1'b0) begin n_err++; $display("FAIL rstlock_wen got %b exp 0", dmem_wen); end
    @(posedge clk); #1;
    n_vec++; if (port_grant !== 4'b0000) begin n_err++; $display("FAIL rstlock_hold got %b exp 0000", port_grant); end
    n_vec++; if (contention_cnt !== '0) begin n_err++; $display("FAIL rstlock_cnt got %0d exp 0", contention_cnt); end
    clear_inputs();
    m_held = 0; m_owner = 0; m_cnt = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 20; c++) begin
      clear_inputs();
      port_req = 4'b1111; port_release = 4'b1111;
      for (int i = 0; i < NP; i++) id_a[i] = IW'($urandom_range(0, 15));
      settle();
      n_vec++; if (port_grant !== exp_grant) begin n_err++; $display("FAIL sat_grant got %b exp %b", port_grant, exp_grant); end
      advance();
    end
    clear_inputs(); settle();
    n_vec++; if (contention_cnt !== 4'hF) begin n_err++; $display("FAIL sat_cnt got %0d exp 15", contention_cnt); end
    n_vec++; if (contention_cnt !== exp_cnt) begin n_err++; $display("FAIL sat_model got %0d exp %0d", contention_cnt, exp_cnt); end
  endtask

  task automatic test_random();
    int base = 40;
    for (int c = 0; c < 400; c++) begin
      base = (base + int'($urandom_range(0, 1))) % 64;
      port_req     = NP'($urandom);
      port_release = NP'($urandom) & NP'($urandom);
      port_wen     = NP'($urandom);
      for (int i = 0; i < NP; i++) begin
        id_a[i]    = IW'((base + int'($urandom_range(0, 20))) % 64);
        addr_a[i]  = 30'($urandom);
        wdata_a[i] = $urandom;
      end
      settle();
      n_vec++; if (port_grant !== exp_grant) begin n_err++; $display("FAIL rnd_grant c=%0d got %b exp %b", c, port_grant, exp_grant); end
      n_vec++; if (dmem_wen !== exp_wen) begin n_err++; $display("FAIL rnd_wen c=%0d got %b exp %b", c, dmem_wen, exp_wen); end
      n_vec++; if (dmem_addr !== exp_addr) begin n_err++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, dmem_addr, exp_addr); end
      n_vec++; if (dmem_wdata !== exp_wdata) begin n_err++; $display("FAIL rnd_wdata c=%0d got %h exp %h", c, dmem_wdata, exp_wdata); end
      n_vec++; if (port_rdata !== exp_rdata) begin n_err++; $display("FAIL rnd_rdata c=%0d got %h exp %h", c, port_rdata, exp_rdata); end
      n_vec++; if (locked !== exp_locked) begin n_err++; $display("FAIL rnd_locked c=%0d got %b exp %b", c, locked, exp_locked); end
      n_vec++; if (contention_cnt !== exp_cnt) begin n_err++; $display("FAIL rnd_cnt c=%0d got %0d exp %0d", c, contention_cnt, exp_cnt); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_wrap_arbitration();
    test_tie_break();
    test_multi_cycle_lock();
    test_abort();
    test_reset_mid_lock();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
